input_port_ctrl: RTL

- Per-port wormhole controller directly downstream of the input buffer FIFO.
- Pops flits from the buffer and decodes the head flit.
- Computes an XY-routed output-port request and holds it at the switch allocator until granted.
- Once granted, streams head, body and tail flits to the crossbar, then releases the request after the tail leaves.

---
 rtl/input_port_ctrl_if.sv | 38 +++
 rtl/input_port_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/input_port_ctrl_if.sv
// rtl/input_port_ctrl_if.sv - buffer, allocator and crossbar signals of one input port
//
// Purpose: groups every handshake between the input port controller and its
// neighbours (input buffer FIFO, switch allocator, crossbar).
// Signals:
//   buf_empty  : buffer empty flag (buffer -> controller)
//   buf_data   : buffer read data, valid the cycle after buf_rd_en
//   buf_rd_en  : pop one flit from the buffer (controller -> buffer)
//   req        : one-hot output request {L,W,S,E,N} (controller -> allocator)
//   grant      : allocator grant for the current req (allocator -> controller)
//   out_ready  : crossbar can accept a flit this cycle
//   flit_out   : flit to crossbar
//   flit_valid : flit_out valid; transfer when flit_valid && out_ready
//   bad_head   : one-cycle pulse when a non-head flit is dropped
// Modports: master = controller side, slave = environment side.
interface input_port_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_rd_en;
  logic [4:0]            req;
  logic                  grant;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] flit_out;
  logic                  flit_valid;
  logic                  bad_head;

  modport master (
    input  buf_empty, buf_data, grant, out_ready,
    output buf_rd_en, req, flit_out, flit_valid, bad_head
  );

  modport slave (
    output buf_empty, buf_data, grant, out_ready,
    input  buf_rd_en, req, flit_out, flit_valid, bad_head
  );
endinterface

// File: rtl/input_port_ctrl.sv
// rtl/input_port_ctrl.sv - per-port wormhole controller with XY routing
//
// Purpose: pops flits from the input buffer, decodes the head flit, raises an
// XY-routed one-hot request at the switch allocator, then streams the packet
// to the crossbar through a 2-entry staging queue and drops the request once
// the tail has left.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : input_port_ctrl_if.master (buffer, allocator and crossbar signals)
module input_port_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int X_WIDTH    = 2,
  parameter int Y_WIDTH    = 2,
  parameter int CUR_X      = 0,
  parameter int CUR_Y      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input_port_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, HEAD_WAIT, ALLOC, XFER} state_t;

  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  localparam logic [X_WIDTH-1:0] LP_CUR_X = X_WIDTH'(CUR_X);
  localparam logic [Y_WIDTH-1:0] LP_CUR_Y = Y_WIDTH'(CUR_Y);

  localparam logic [4:0] R_N = 5'b00001;
  localparam logic [4:0] R_E = 5'b00010;
  localparam logic [4:0] R_S = 5'b00100;
  localparam logic [4:0] R_W = 5'b01000;
  localparam logic [4:0] R_L = 5'b10000;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_q [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_cnt;
  logic                  r_rd_pending;
  logic                  r_tail_fetched;
  logic [4:0]            r_req;

  logic [1:0]            w_in_type;
  logic                  w_in_is_head;
  logic [X_WIDTH-1:0]    w_dest_x;
  logic [Y_WIDTH-1:0]    w_dest_y;
  logic [4:0]            w_route;
  logic                  w_flit_valid;
  logic                  w_fire;
  logic                  w_out_last;
  logic                  w_clear;
  logic                  w_streaming;
  logic                  w_tail_in;
  logic                  w_tail_seen;
  logic [2:0]            w_occ;
  logic                  w_prefetch;
  logic                  w_push;
  logic                  w_rd_en;
  logic                  w_bad;

  // Head types 01 and 11 both have the low type bit set.
  assign w_in_type    = bus.buf_data[DATA_WIDTH-1 -: 2];
  assign w_in_is_head = w_in_type[0];
  assign w_dest_x     = bus.buf_data[X_WIDTH+Y_WIDTH-1:Y_WIDTH];
  assign w_dest_y     = bus.buf_data[Y_WIDTH-1:0];

  assign w_streaming  = (r_state == ALLOC) || (r_state == XFER);
  assign w_flit_valid = (r_state == XFER) && (r_cnt != 2'd0);
  assign w_fire       = w_flit_valid && bus.out_ready;
  // Types 10 and 11 both close the packet: high type bit set.
  assign w_out_last   = r_q[r_rd_ptr][DATA_WIDTH-1];
  assign w_clear      = w_fire && w_out_last;

  // A tail arriving this cycle must already block the next pop, otherwise the
  // read issued alongside its capture would pull a flit of the next packet.
  assign w_tail_in    = w_streaming && r_rd_pending && (w_in_type == T_TAIL);
  assign w_tail_seen  = r_tail_fetched || w_tail_in;

  // Occupancy after this cycle, counting the flit still in flight from the buffer.
  assign w_occ      = {1'b0, r_cnt} + {2'b00, r_rd_pending} - {2'b00, w_fire};
  assign w_prefetch = !bus.buf_empty && !w_tail_seen && (w_occ < 3'd2);

  assign w_push = r_rd_pending &&
                  (((r_state == HEAD_WAIT) && w_in_is_head) || w_streaming);

  always_comb begin
    w_route = R_L;
    if (w_dest_x > LP_CUR_X)      w_route = R_E;
    else if (w_dest_x < LP_CUR_X) w_route = R_W;
    else if (w_dest_y > LP_CUR_Y) w_route = R_N;
    else if (w_dest_y < LP_CUR_Y) w_route = R_S;
    else                          w_route = R_L;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      IDLE: begin
        w_rd_en = !bus.buf_empty;
        if (w_rd_en) w_state_nxt = HEAD_WAIT;
      end
      HEAD_WAIT: begin
        if (!w_in_is_head) begin
          w_bad       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ALLOC;
        end
      end
      ALLOC: begin
        w_rd_en = w_prefetch;
        if (bus.grant) w_state_nxt = XFER;
      end
      XFER: begin
        w_rd_en = w_prefetch;
        if (w_clear) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q[0]         <= '0;
      r_q[1]         <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_cnt          <= 2'd0;
      r_rd_pending   <= 1'b0;
      r_tail_fetched <= 1'b0;
      r_req          <= '0;
    end else begin
      r_rd_pending <= w_rd_en;

      if ((r_state == HEAD_WAIT) && w_in_is_head) r_req <= w_route;
      else if (w_clear)                           r_req <= '0;

      if (w_clear)
        r_tail_fetched <= 1'b0;
      else if ((r_state == HEAD_WAIT) && (w_in_type == T_SINGLE))
        r_tail_fetched <= 1'b1;
      else if (w_tail_in)
        r_tail_fetched <= 1'b1;

      // Tail departure discards anything left in the queue.
      if (w_clear) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_cnt    <= 2'd0;
      end else begin
        if (w_push) begin
          r_q[r_wr_ptr] <= bus.buf_data;
          r_wr_ptr      <= ~r_wr_ptr;
        end
        if (w_fire) r_rd_ptr <= ~r_rd_ptr;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_fire};
      end
    end
  end

  // Read enable is forced low while reset is held so the buffer is never popped.
  assign bus.buf_rd_en  = w_rd_en & rst;
  assign bus.req        = r_req;
  assign bus.flit_valid = w_flit_valid;
  assign bus.flit_out   = w_flit_valid ? r_q[r_rd_ptr] : '0;
  assign bus.bad_head   = w_bad;

endmodule
